mutex_arbiter: RTL and testbench

//  Hardware mutual-exclusion arbiter that gives one shared critical resource to N requesters.
//  It replaces the software entry/exit protocol (interested flags plus a turn variable) with a

---
 rtl/mutex_pkg.sv | 15 +
 rtl/mutex_arbiter_rr_pick.sv | 40 ++++
 rtl/mutex_arbiter.sv | 124 ++++++++++++
 tb/tb_mutex_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mutex_pkg.sv
// mutex_pkg: shared FSM state encoding and index helper for the mutex arbiter.
package mutex_pkg;

    typedef enum logic [1:0] {
        FREE  = 2'd0,
        HELD  = 2'd1,
        DRAIN = 2'd2
    } mtx_state_t;

    // Successor of idx in a ring of n slots; explicit compare so n need not be a power of 2.
    function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/mutex_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker. Scans turn, turn+1, ... (mod N) and
// reports the first requester found.
module rr_pick
    import mutex_pkg::*;
#(
    parameter int N   = 2,
    parameter int IDW = 1
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] turn,
    output logic           any,
    output logic [IDW-1:0] pick
);

    // Candidate index for scan position gi, wrapped by compare-and-subtract.
    logic [IDW:0]   sum [N];
    logic [IDW-1:0] idx [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_scan
            assign sum[gi] = {1'b0, turn} + (IDW+1)'(gi);
            assign idx[gi] = (sum[gi] >= (IDW+1)'(N)) ? IDW'(sum[gi] - (IDW+1)'(N))
                                                      : IDW'(sum[gi]);
        end
    endgenerate

    // Walk from the farthest scan position back to turn so the nearest hit wins.
    always_comb begin
        any  = 1'b0;
        pick = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[idx[k]]) begin
                any  = 1'b1;
                pick = idx[k];
            end
        end
    end

endmodule

// File: rtl/mutex_arbiter.sv
// mutex_arbiter: registered request/grant/release mutual-exclusion arbiter for N requesters.
// Optional grant-hold timeout is built when MUTEX_TIMEOUT_EN is defined; otherwise a grant
// is held until its owner releases it and timeout is tied low.
module mutex_arbiter
    import mutex_pkg::*;
#(
    parameter int N        = 2,
    parameter int IDW      = (N > 2) ? $clog2(N) : 1,
    parameter int HOLD_MAX = 15
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   rel,
    output logic [N-1:0]   grant,
    output logic           busy,
    output logic [IDW-1:0] owner,
    output logic [IDW-1:0] turn,
    output logic           timeout
);

    generate
        if (N < 2 || N > 8 || HOLD_MAX < 1) begin : g_bad_cfg
            $error("mutex_arbiter: N must be 2..8 and HOLD_MAX at least 1");
        end
    endgenerate

    mtx_state_t     state_q;
    logic [N-1:0]   grant_q;
    logic [IDW-1:0] owner_q;
    logic [IDW-1:0] turn_q;

    logic           pick_any;
    logic [IDW-1:0] pick_idx;
    logic [IDW-1:0] next_turn;
    logic           rel_own;
    logic           limit_hit;

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req  (req),
        .turn (turn_q),
        .any  (pick_any),
        .pick (pick_idx)
    );

    // Only the current owner's release bit matters; everyone else's is ignored.
    assign rel_own   = rel[owner_q];
    assign next_turn = IDW'(next_idx(32'(owner_q), 32'(N)));

`ifdef MUTEX_TIMEOUT_EN
    localparam int HW = $clog2(HOLD_MAX + 1);
    logic [HW-1:0] hold_q;
    logic          timeout_q;

    // hold_q counts completed HELD cycles, so the limit fires in the HOLD_MAX-th one.
    assign limit_hit = (hold_q == HW'(HOLD_MAX - 1));
    assign timeout   = timeout_q;
`else
    assign limit_hit = 1'b0;
    assign timeout   = 1'b0;
`endif

    // FSM: grant on a FREE pick, drop on release or revoke, then one idle DRAIN cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FREE;
            grant_q <= '0;
            owner_q <= '0;
            turn_q  <= '0;
`ifdef MUTEX_TIMEOUT_EN
            hold_q    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
`ifdef MUTEX_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state_q)
                FREE: begin
                    if (pick_any) begin
                        state_q <= HELD;
                        grant_q <= N'(1) << pick_idx;
                        owner_q <= pick_idx;
`ifdef MUTEX_TIMEOUT_EN
                        hold_q  <= '0;
`endif
                    end
                end
                HELD: begin
                    if (rel_own || limit_hit) begin
                        state_q <= DRAIN;
                        grant_q <= '0;
                        owner_q <= '0;
                        turn_q  <= next_turn;
`ifdef MUTEX_TIMEOUT_EN
                        // A release in the limit cycle is a normal release, not a revoke.
                        timeout_q <= limit_hit && !rel_own;
`endif
                    end
`ifdef MUTEX_TIMEOUT_EN
                    else begin
                        hold_q <= hold_q + 1'b1;
                    end
`endif
                end
                DRAIN: begin
                    state_q <= FREE;
                end
                default: begin
                    state_q <= FREE;
                end
            endcase
        end
    end

    assign grant = grant_q;
    assign busy  = |grant_q;
    assign owner = owner_q;
    assign turn  = turn_q;

endmodule

// File: tb/tb_mutex_arbiter.sv
// Testbench for mutex_arbiter: two instances (N=2 and N=4) checked every cycle against a
// behavioural model, plus directed scenarios with literal expectations.
// Build with MUTEX_TIMEOUT_EN defined to exercise the hold timeout.
module tb_mutex_arbiter;

    localparam int HOLD_MAX = 15;
`ifdef MUTEX_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n = 1'b1;
    logic [1:0] req2 = '0, rel2 = '0, grant2;
    logic       busy2, owner2, turn2, tmo2;
    logic [3:0] req4 = '0, rel4 = '0, grant4;
    logic       busy4, tmo4;
    logic [1:0] owner4, turn4;

    mutex_arbiter #(.N(2), .IDW(1), .HOLD_MAX(HOLD_MAX)) dut2 (
        .clock(clk), .reset_n(reset_n), .req(req2), .rel(rel2), .grant(grant2),
        .busy(busy2), .owner(owner2), .turn(turn2), .timeout(tmo2));

    mutex_arbiter #(.N(4), .IDW(2), .HOLD_MAX(HOLD_MAX)) dut4 (
        .clock(clk), .reset_n(reset_n), .req(req4), .rel(rel4), .grant(grant4),
        .busy(busy4), .owner(owner4), .turn(turn4), .timeout(tmo4));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 = resource free, 1 = owned, 2 = idle gap after an owner lets go.
    typedef struct {
        int phase;
        int owner;
        int turn;
        int held;    // HELD cycles already completed by the current owner
        bit pulse;
    } mstate_t;

    localparam mstate_t M_RST = '{phase: 0, owner: 0, turn: 0, held: 0, pulse: 1'b0};

    function automatic mstate_t mstep(input mstate_t s, input int n,
                                      input logic [7:0] rq, input logic [7:0] rl);
        mstate_t t = s;
        bit found = 1'b0;
        t.pulse = 1'b0;
        if (s.phase == 0) begin
            for (int k = 0; k < n; k++) begin
                int c = (s.turn + k) % n;
                if (!found && rq[c]) begin
                    found   = 1'b1;
                    t.phase = 1;
                    t.owner = c;
                    t.held  = 0;
                end
            end
        end else if (s.phase == 1) begin
            if (rl[s.owner]) begin
                t.phase = 2; t.turn = (s.owner + 1) % n; t.owner = 0;
            end else if (TMO_EN && s.held + 1 >= HOLD_MAX) begin
                t.phase = 2; t.turn = (s.owner + 1) % n; t.owner = 0; t.pulse = 1'b1;
            end else begin
                t.held = s.held + 1;
            end
        end else begin
            t.phase = 0;
        end
        return t;
    endfunction

    function automatic int exp_grant(input mstate_t s);
        return (s.phase == 1) ? (1 << s.owner) : 0;
    endfunction

    function automatic bit legal_change(input logic [3:0] a, input logic [3:0] b);
        return (a == b) || (a == 4'd0 && $onehot(b)) || (a != 4'd0 && b == 4'd0);
    endfunction

    mstate_t m2 = M_RST;
    mstate_t m4 = M_RST;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m2 <= M_RST;
            m4 <= M_RST;
        end else begin
            m2 <= mstep(m2, 2, {6'b0, req2}, {6'b0, rel2});
            m4 <= mstep(m4, 4, {4'b0, req4}, {4'b0, rel4});
        end
    end

    // ---------------- per-cycle compare ----------------
    bit         en_cmp = 1'b0;
    int         tcount = 0;
    logic [3:0] prev_g2 = '0, prev_g4 = '0;

    always @(negedge clk) begin
        if (en_cmp) begin
            chk("grant2", grant2, exp_grant(m2));
            chk("owner2", owner2, (m2.phase == 1) ? m2.owner : 0);
            chk("turn2", turn2, m2.turn);
            chk("busy2", busy2, m2.phase == 1);
            chk("timeout2", tmo2, m2.pulse);
            chk("onehot2", $onehot0(grant2), 1);
            chk("own_inv2", grant2[owner2], busy2);
            chk("gchg2", legal_change({2'b0, prev_g2[1:0]}, {2'b0, grant2}), 1);
            chk("grant4", grant4, exp_grant(m4));
            chk("owner4", owner4, (m4.phase == 1) ? m4.owner : 0);
            chk("turn4", turn4, m4.turn);
            chk("busy4", busy4, m4.phase == 1);
            chk("timeout4", tmo4, m4.pulse);
            chk("onehot4", $onehot0(grant4), 1);
            chk("own_inv4", grant4[owner4], busy4);
            chk("gchg4", legal_change(prev_g4, grant4), 1);
            prev_g2 <= {2'b0, grant2};
            prev_g4 <= grant4;
            if (tmo2) tcount <= tcount + 1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_g2(output logic [1:0] g);
        int n = 0;
        while (grant2 == 2'b00 && n < 20) begin
            tick();
            n++;
        end
        chk("wait_grant2", grant2 != 2'b00, 1);
        g = grant2;
    endtask

    task automatic wait_g4(output logic [3:0] g);
        int n = 0;
        while (grant4 == 4'b0000 && n < 20) begin
            tick();
            n++;
        end
        chk("wait_grant4", grant4 != 4'b0000, 1);
        g = grant4;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        logic [1:0] g2;
        logic [3:0] g4;
        logic [1:0] seq [3];
        int order [5];
        int t0;
        int n;

        #1 reset_n = 1'b0;
        en_cmp = 1'b1;

        // 1: reset with both requesting, then first grant one cycle after release
        req2 = 2'b11;
        tick();
        chk("t1_rst_grant", grant2, 2'b00);
        chk("t1_rst_turn", turn2, 0);
        reset_n = 1'b1;
        tick();
        chk("t1_first_grant", grant2, 2'b01);

        // 2: contention, release two cycles after each grant
        for (int i = 0; i < 3; i++) begin
            wait_g2(g2);
            seq[i] = g2;
            $display("t2 grant %0d = %b", i, g2);
            tick();
            tick();
            rel2 = g2;
            tick();
            rel2 = 2'b00;
        end
        chk("t2_seq0", seq[0], 2'b01);
        chk("t2_seq1", seq[1], 2'b10);
        chk("t2_seq2", seq[2], 2'b01);
        chk("t2_turn", turn2, 1);
        req2 = 2'b00;

        // 3: stray release ignored, multi-bit release only counts the owner
        pulse_reset();
        req2 = 2'b01;
        wait_g2(g2);
        req2 = 2'b00;
        rel2 = 2'b10;
        tick();
        rel2 = 2'b00;
        tick();
        chk("t3_stray_grant", grant2, 2'b01);
        chk("t3_stray_owner", owner2, 0);
        rel2 = 2'b11;
        tick();
        rel2 = 2'b00;
        chk("t3_rel_grant", grant2, 2'b00);
        chk("t3_rel_turn", turn2, 1);
        $display("t3 release done turn=%0d", turn2);

        // 4: async reset while requester 1 holds the grant
        req2 = 2'b10;
        wait_g2(g2);
        chk("t4_grant", g2, 2'b10);
        reset_n = 1'b0;
        #1;
        chk("t4_async_grant", grant2, 2'b00);
        chk("t4_async_owner", owner2, 0);
        chk("t4_async_turn", turn2, 0);
        req2 = 2'b00;
        tick();
        reset_n = 1'b1;
        tick();
        $display("t4 async reset done");

        // 5: fairness with four continuous requesters
        req4 = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_g4(g4);
            order[i] = -1;
            for (int b = 0; b < 4; b++) if (g4[b]) order[i] = b;
            $display("t5 grant %0d -> requester %0d", i, order[i]);
            tick();
            rel4 = g4;
            tick();
            rel4 = 4'b0000;
            if (i == 3) chk("t5_turn_wrap", turn4, 0);
        end
        chk("t5_order0", order[0], 0);
        chk("t5_order1", order[1], 1);
        chk("t5_order2", order[2], 2);
        chk("t5_order3", order[3], 3);
        chk("t5_order4", order[4], 0);
        req4 = 4'b0000;

        // 6: hold limit
        pulse_reset();
        req2 = 2'b01;
        wait_g2(g2);
        t0 = tcount;
        n  = 1;
`ifdef MUTEX_TIMEOUT_EN
        while (grant2 != 2'b00 && n < 40) begin
            tick();
            if (grant2 != 2'b00) n++;
        end
        tick();
        chk("t6_held_cycles", n, HOLD_MAX);
        chk("t6_pulses", tcount - t0, 1);
        $display("t6 revoke after %0d cycles", n);
        wait_g2(g2);
        t0 = tcount;
        repeat (HOLD_MAX - 1) tick();
        chk("t6_still_held", grant2, 2'b01);
        rel2 = 2'b01;
        tick();
        rel2 = 2'b00;
        chk("t6_rel_grant", grant2, 2'b00);
        tick();
        tick();
        chk("t6_no_pulse", tcount - t0, 0);
        $display("t6 release on limit cycle");
`else
        repeat (HOLD_MAX + 5) begin
            tick();
            n++;
        end
        chk("t6_hold_forever", grant2, 2'b01);
        chk("t6_no_pulse", tcount - t0, 0);
        $display("t6 grant held %0d cycles", n);
        rel2 = 2'b01;
        tick();
        rel2 = 2'b00;
`endif
        req2 = 2'b00;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
